// File: rtl/bids_mc_if.sv
// bids_mc_if: auction bus (start/round_len/reserve, credit load, per-bidder bids in; ack/err, busy/done, result out)
interface bids_mc_if #(parameter int NBID = 4, parameter int VW = 16, parameter int TW = 16);
  logic                    start;
  logic [TW-1:0]           round_len;
  logic [VW-1:0]           reserve;
  logic [NBID-1:0]         credit_ld;
  logic [NBID*VW-1:0]      credit_val;
  logic [NBID-1:0]         bid_valid;
  logic [NBID*VW-1:0]      bid_amt;
  logic [NBID-1:0]         bid_ack;
  logic [NBID-1:0]         bid_err;
  logic                    busy;
  logic                    done;
  logic                    win_valid;
  logic [$clog2(NBID)-1:0] winner_id;
  logic [VW-1:0]           win_price;
  modport master (
    output start, round_len, reserve, credit_ld, credit_val, bid_valid, bid_amt,
    input  bid_ack, bid_err, busy, done, win_valid, winner_id, win_price
  );
  modport slave (
    input  start, round_len, reserve, credit_ld, credit_val, bid_valid, bid_amt,
    output bid_ack, bid_err, busy, done, win_valid, winner_id, win_price
  );
endinterface

// File: rtl/bids_mc.sv
// bids_mc: timed sealed-credit auction over NBID bidders; clk, async reset, bids_mc_if.slave bus carries control, bids and results
module bids_mc #(
  parameter int NBID = 4,
  parameter int VW   = 16,
  parameter int TW   = 16
) (
  input logic      clk,
  input logic      reset,
  bids_mc_if.slave bus
);
  localparam int IW = $clog2(NBID);
  typedef enum logic [1:0] {IDLE, ROUND, RESOLVE} state_t;
  state_t          state;
  logic [TW-1:0]   timer;
  logic [VW-1:0]   credit [NBID];
  logic [VW-1:0]   high;
  logic [VW-1:0]   reserve_r;
  logic            leader_v;
  logic [IW-1:0]   leader;
  logic            best_v;
  logic [IW-1:0]   best_i;
  logic [VW-1:0]   best_a;
  logic [NBID-1:0] ack_nxt;
  always_comb begin
    best_v = 1'b0;
    best_i = '0;
    best_a = '0;
    for (int i = 0; i < NBID; i++) begin
      if (state == ROUND && bus.bid_valid[i] &&
          bus.bid_amt[i*VW +: VW] >= reserve_r &&
          bus.bid_amt[i*VW +: VW] > high &&
          bus.bid_amt[i*VW +: VW] <= credit[i] &&
          (!best_v || bus.bid_amt[i*VW +: VW] > best_a)) begin
        best_v = 1'b1;
        best_i = IW'(i);
        best_a = bus.bid_amt[i*VW +: VW];
      end
    end
    ack_nxt = best_v ? NBID'(1) << best_i : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      high          <= '0;
      reserve_r     <= '0;
      leader_v      <= 1'b0;
      leader        <= '0;
      bus.bid_ack   <= '0;
      bus.bid_err   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.win_valid <= 1'b0;
      bus.winner_id <= '0;
      bus.win_price <= '0;
      for (int i = 0; i < NBID; i++) credit[i] <= '0;
    end else begin
      bus.bid_ack <= ack_nxt;
      bus.bid_err <= bus.bid_valid & ~ack_nxt;
      if (best_v) begin
        high     <= best_a;
        leader   <= best_i;
        leader_v <= 1'b1;
      end
      case (state)
        IDLE: begin
          for (int i = 0; i < NBID; i++)
            if (bus.credit_ld[i]) credit[i] <= bus.credit_val[i*VW +: VW];
          if (bus.start) begin
            state         <= ROUND;
            bus.busy      <= 1'b1;
            timer         <= (bus.round_len == '0) ? TW'(1) : bus.round_len;
            reserve_r     <= bus.reserve;
            high          <= '0;
            leader_v      <= 1'b0;
            bus.win_valid <= 1'b0;
          end
        end
        ROUND: begin
          timer <= timer - TW'(1);
          if (timer == TW'(1)) begin
            state    <= RESOLVE;
            bus.done <= 1'b1;
          end
        end
        RESOLVE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
          bus.win_valid <= leader_v;
          if (leader_v) begin
            bus.winner_id  <= leader;
            bus.win_price  <= high;
            credit[leader] <= credit[leader] - high;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bids_mc.sv
// tb_bids_mc: directed vectors with hand-computed expectations for bids_mc
module tb_bids_mc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  bids_mc_if #(.NBID(4), .VW(16), .TW(16)) bus ();
  bids_mc #(.NBID(4), .VW(16), .TW(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_bid(input logic [3:0] v, input logic [15:0] a0, a1, a2, a3);
    bus.bid_valid = v;
    bus.bid_amt   = {a3, a2, a1, a0};
  endtask
  task automatic start_round(input logic [15:0] len, input logic [15:0] res);
    bus.start     = 1'b1;
    bus.round_len = len;
    bus.reserve   = res;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.round_len = 0; bus.reserve = 0;
    bus.credit_ld = 0; bus.credit_val = 0; bus.bid_valid = 0; bus.bid_amt = 0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack", bus.bid_ack, 0);
    chk("rst_winv", bus.win_valid, 0);
    reset = 1'b0;
    bus.credit_ld = 4'hF;
    bus.credit_val = {4{16'd100}};
    tick();
    bus.credit_ld = 0;
    chk("ld_credit2", dut.credit[2], 100);
    start_round(5, 10);
    chk("t1_busy", bus.busy, 1);
    set_bid(4'b0010, 0, 20, 0, 0);
    tick();
    chk("t1_ack1", bus.bid_ack, 4'b0010);
    chk("t1_err1", bus.bid_err, 0);
    set_bid(4'b0100, 0, 0, 30, 0);
    tick();
    chk("t1_ack2", bus.bid_ack, 4'b0100);
    set_bid(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t1_nodone", bus.done, 0);
    tick();
    chk("t1_done", bus.done, 1);
    chk("t1_busy_res", bus.busy, 1);
    tick();
    chk("t1_done_off", bus.done, 0);
    chk("t1_idle", bus.busy, 0);
    chk("t1_winv", bus.win_valid, 1);
    chk("t1_id", bus.winner_id, 2);
    chk("t1_price", bus.win_price, 30);
    chk("t1_credit2", dut.credit[2], 70);
    chk("t1_credit1", dut.credit[1], 100);
    start_round(3, 10);
    set_bid(4'b1011, 50, 40, 0, 50);
    tick();
    chk("t2_ack", bus.bid_ack, 4'b0001);
    chk("t2_err", bus.bid_err, 4'b1010);
    set_bid(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t2_done", bus.done, 1);
    tick();
    chk("t2_id", bus.winner_id, 0);
    chk("t2_price", bus.win_price, 50);
    chk("t2_credit0", dut.credit[0], 50);
    start_round(2, 10);
    chk("t3_winv_clr", bus.win_valid, 0);
    set_bid(4'b0011, 5, 150, 0, 0);
    tick();
    chk("t3_ack", bus.bid_ack, 0);
    chk("t3_err", bus.bid_err, 4'b0011);
    set_bid(0, 0, 0, 0, 0);
    tick();
    chk("t3_done", bus.done, 1);
    tick();
    chk("t3_winv", bus.win_valid, 0);
    chk("t3_credit0", dut.credit[0], 50);
    chk("t3_credit1", dut.credit[1], 100);
    set_bid(4'b0100, 0, 0, 20, 0);
    tick();
    chk("idle_err", bus.bid_err, 4'b0100);
    set_bid(0, 0, 0, 0, 0);
    start_round(0, 10);
    set_bid(4'b1000, 0, 0, 0, 60);
    tick();
    chk("t4_ack", bus.bid_ack, 4'b1000);
    chk("t4_done", bus.done, 1);
    set_bid(0, 0, 0, 0, 0);
    tick();
    chk("t4_winv", bus.win_valid, 1);
    chk("t4_id", bus.winner_id, 3);
    chk("t4_price", bus.win_price, 60);
    chk("t4_credit3", dut.credit[3], 40);
    start_round(4, 10);
    bus.credit_ld = 4'hF;
    bus.credit_val = {4{16'd999}};
    bus.start = 1'b1;
    bus.round_len = 9;
    tick();
    bus.credit_ld = 0;
    bus.start = 0;
    chk("t5_timer", dut.timer, 3);
    chk("t5_credit0", dut.credit[0], 50);
    tick();
    tick();
    chk("t5_nodone", bus.done, 0);
    tick();
    chk("t5_done", bus.done, 1);
    tick();
    chk("t5_winv", bus.win_valid, 0);
    chk("t5_credit1", dut.credit[1], 100);
    chk("t5_keep_id", bus.winner_id, 3);
    start_round(5, 10);
    set_bid(4'b0010, 0, 20, 0, 0);
    tick();
    chk("t6_ack", bus.bid_ack, 4'b0010);
    set_bid(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t6_timer", dut.timer, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_id", bus.winner_id, 0);
    chk("t6_price", bus.win_price, 0);
    chk("t6_credit1", dut.credit[1], 0);
    chk("t6_credit2", dut.credit[2], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_nodone", bus.done, 0);
    end
    reset = 1'b0;
    start_round(2, 10);
    chk("t6_restart", bus.busy, 1);
    tick();
    tick();
    chk("t6_rdone", bus.done, 1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
